// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared widths, FSM states and the 50-entry cos/sin demodulation table
package demod_pkg;

    localparam int DEMOD_LUT_SIZE = 50;
    localparam int SAMPLE_W       = 16;
    localparam int LUT_W          = 16;
    localparam int LANE_OUT_W     = 18;
    localparam int ACC_W          = 40;
    localparam int PHASE_IDX_W    = 6;
    localparam int DRAIN_CYCLES   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } demod_state_t;

    // round(32767*cos(2*pi*p/50)) and round(32767*sin(2*pi*p/50))
    localparam logic signed [LUT_W-1:0] COS_LUT [DEMOD_LUT_SIZE] = '{
         16'sd32767,  16'sd32509,  16'sd31738,  16'sd30466,  16'sd28714,
         16'sd26509,  16'sd23886,  16'sd20886,  16'sd17557,  16'sd13952,
         16'sd10126,  16'sd6140,   16'sd2057,  -16'sd2057,  -16'sd6140,
        -16'sd10126, -16'sd13952, -16'sd17557, -16'sd20886, -16'sd23886,
        -16'sd26509, -16'sd28714, -16'sd30466, -16'sd31738, -16'sd32509,
        -16'sd32767, -16'sd32509, -16'sd31738, -16'sd30466, -16'sd28714,
        -16'sd26509, -16'sd23886, -16'sd20886, -16'sd17557, -16'sd13952,
        -16'sd10126, -16'sd6140,  -16'sd2057,   16'sd2057,   16'sd6140,
         16'sd10126,  16'sd13952,  16'sd17557,  16'sd20886,  16'sd23886,
         16'sd26509,  16'sd28714,  16'sd30466,  16'sd31738,  16'sd32509
    };

    localparam logic signed [LUT_W-1:0] SIN_LUT [DEMOD_LUT_SIZE] = '{
         16'sd0,      16'sd4107,   16'sd8149,   16'sd12062,  16'sd15786,
         16'sd19260,  16'sd22431,  16'sd25247,  16'sd27666,  16'sd29648,
         16'sd31163,  16'sd32187,  16'sd32702,  16'sd32702,  16'sd32187,
         16'sd31163,  16'sd29648,  16'sd27666,  16'sd25247,  16'sd22431,
         16'sd19260,  16'sd15786,  16'sd12062,  16'sd8149,   16'sd4107,
         16'sd0,     -16'sd4107,  -16'sd8149,  -16'sd12062, -16'sd15786,
        -16'sd19260, -16'sd22431, -16'sd25247, -16'sd27666, -16'sd29648,
        -16'sd31163, -16'sd32187, -16'sd32702, -16'sd32702, -16'sd32187,
        -16'sd31163, -16'sd29648, -16'sd27666, -16'sd25247, -16'sd22431,
        -16'sd19260, -16'sd15786, -16'sd12062, -16'sd8149,  -16'sd4107
    };

endpackage

// File: rtl/demod_lane.sv
// rtl/demod_lane.sv - one lane: phase LUT, rotation products and floor shift (3 register stages)
module demod_lane
    import demod_pkg::*;
(
    input  logic                   clk100,
    input  logic                   reset,
    input  logic [SAMPLE_W-1:0]    data_i,
    input  logic [SAMPLE_W-1:0]    data_q,
    input  logic [PHASE_IDX_W-1:0] phase,
    output logic [LANE_OUT_W-1:0]  rot_i,
    output logic [LANE_OUT_W-1:0]  rot_q
);
    localparam int PROD_W = SAMPLE_W + LUT_W;
    localparam int SUM_W  = PROD_W + 1;

    logic [PHASE_IDX_W-1:0]     lut_idx;
    logic signed [SAMPLE_W-1:0] s1_i, s1_q;
    logic signed [LUT_W-1:0]    s1_cos, s1_sin;
    logic signed [PROD_W-1:0]   p_ic, p_qs, p_qc, p_is;
    logic signed [SUM_W-1:0]    sum_i, sum_q;

    // Indices past the end of the table alias to phase 0
    assign lut_idx = (phase < PHASE_IDX_W'(DEMOD_LUT_SIZE)) ? phase : '0;

    assign sum_i = SUM_W'(p_ic) + SUM_W'(p_qs);
    assign sum_q = SUM_W'(p_qc) - SUM_W'(p_is);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            s1_i   <= '0;
            s1_q   <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
            p_ic   <= '0;
            p_qs   <= '0;
            p_qc   <= '0;
            p_is   <= '0;
            rot_i  <= '0;
            rot_q  <= '0;
        end else begin
            s1_i   <= data_i;
            s1_q   <= data_q;
            s1_cos <= COS_LUT[lut_idx];
            s1_sin <= SIN_LUT[lut_idx];
            p_ic   <= PROD_W'(s1_i) * PROD_W'(s1_cos);
            p_qs   <= PROD_W'(s1_q) * PROD_W'(s1_sin);
            p_qc   <= PROD_W'(s1_q) * PROD_W'(s1_cos);
            p_is   <= PROD_W'(s1_i) * PROD_W'(s1_sin);
            // Dropping the low 15 bits of the signed sum floors toward minus infinity
            rot_i  <= sum_i[SUM_W-1 -: LANE_OUT_W];
            rot_q  <= sum_q[SUM_W-1 -: LANE_OUT_W];
        end
    end

endmodule

// File: rtl/demod_integrator.sv
// rtl/demod_integrator.sv - per-lane phase rotation and windowed I/Q integration; DEMOD_THRESHOLD_EN adds the state comparator
module demod_integrator #(
    parameter int LANES = 5,
    parameter int ACC_W = demod_pkg::ACC_W
) (
    input  logic                   clk100,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [LANES-1:0][15:0] data_i_shift,
    input  logic [LANES-1:0][15:0] data_q_shift,
    input  logic [LANES-1:0][17:0] phase_vals,
`ifdef DEMOD_THRESHOLD_EN
    input  logic [ACC_W-1:0]       threshold,
    output logic                   qubit_state,
`endif
    output logic [ACC_W-1:0]       i_sum,
    output logic [ACC_W-1:0]       q_sum,
    output logic                   result_valid,
    output logic                   busy
);
    import demod_pkg::*;

    localparam int BEAT_W = LANE_OUT_W + $clog2(LANES);

    demod_state_t state, state_nxt;
    logic [1:0]   drain_cnt;
    logic         clear, accept_beat;
    logic [2:0]   vld_pipe;
    logic [ACC_W-1:0] acc_i, acc_q;
    logic [LANES-1:0][LANE_OUT_W-1:0] lane_i, lane_q;
    logic [BEAT_W-1:0] beat_i, beat_q;
    logic [LANES-1:0]  unused_phase_hi;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        demod_lane u_lane (
            .clk100 (clk100),
            .reset  (reset),
            .data_i (data_i_shift[l]),
            .data_q (data_q_shift[l]),
            .phase  (phase_vals[l][PHASE_IDX_W-1:0]),
            .rot_i  (lane_i[l]),
            .rot_q  (lane_q[l])
        );
        assign unused_phase_hi[l] = ^phase_vals[l][17:PHASE_IDX_W];
    end

    always_comb begin
        beat_i = '0;
        beat_q = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_i = beat_i + {{(BEAT_W-LANE_OUT_W){lane_i[l][LANE_OUT_W-1]}}, lane_i[l]};
            beat_q = beat_q + {{(BEAT_W-LANE_OUT_W){lane_q[l][LANE_OUT_W-1]}}, lane_q[l]};
        end
    end

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        accept_beat = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                accept_beat = in_valid;
                if (in_valid && in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            vld_pipe     <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            i_sum        <= '0;
            q_sum        <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            result_valid <= (state == DONE);
            // The valid bit travels alongside the three lane register stages
            vld_pipe     <= clear ? 3'b000 : {vld_pipe[1:0], accept_beat};
            if (clear) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (vld_pipe[2]) begin
                acc_i <= acc_i + {{(ACC_W-BEAT_W){beat_i[BEAT_W-1]}}, beat_i};
                acc_q <= acc_q + {{(ACC_W-BEAT_W){beat_q[BEAT_W-1]}}, beat_q};
            end
            if (state == DONE) begin
                i_sum <= acc_i;
                q_sum <= acc_q;
            end
        end
    end

`ifdef DEMOD_THRESHOLD_EN
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            qubit_state <= 1'b0;
        end else if (state == DONE) begin
            qubit_state <= $signed(acc_i) > $signed(threshold);
        end
    end
`endif

endmodule

// File: tb/tb_demod_integrator.sv
// tb/tb_demod_integrator.sv - self-checking bench for demod_integrator; define DEMOD_THRESHOLD_EN to cover the comparator
module tb_demod_integrator;
    import demod_pkg::*;

    localparam int NL   = 5;
    localparam int MAXB = 32;

    logic clk100 = 1'b0;
    logic reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [NL-1:0][15:0] data_i_shift = '0;
    logic [NL-1:0][15:0] data_q_shift = '0;
    logic [NL-1:0][17:0] phase_vals = '0;
    logic [ACC_W-1:0] i_sum, q_sum;
    logic result_valid, busy;
`ifdef DEMOD_THRESHOLD_EN
    logic [ACC_W-1:0] threshold = '0;
    logic qubit_state;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int st_i [MAXB][NL];
    int st_q [MAXB][NL];
    int st_p [MAXB][NL];
    bit st_v [MAXB];

    typedef struct {
        logic [ACC_W-1:0] i, q, prev_i;
        int   lat;
        logic rv_next, busy_run, busy_rv, qs;
    } obs_t;

    always #5 clk100 = ~clk100;

    demod_integrator #(.LANES(NL), .ACC_W(ACC_W)) dut (
        .clk100       (clk100),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .data_i_shift (data_i_shift),
        .data_q_shift (data_q_shift),
        .phase_vals   (phase_vals),
`ifdef DEMOD_THRESHOLD_EN
        .threshold    (threshold),
        .qubit_state  (qubit_state),
`endif
        .i_sum        (i_sum),
        .q_sum        (q_sum),
        .result_valid (result_valid),
        .busy         (busy)
    );

    function automatic int rand16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Rotation by -phase in exact integer arithmetic, floored by 2^15
    function automatic longint rot(input int i, input int q, input int p, input bit want_q);
        int idx;
        longint c, s, v;
        idx = ((p & 63) < DEMOD_LUT_SIZE) ? (p & 63) : 0;
        c = longint'(COS_LUT[idx]);
        s = longint'(SIN_LUT[idx]);
        v = want_q ? (longint'(q) * c - longint'(i) * s) : (longint'(i) * c + longint'(q) * s);
        return v >>> 15;
    endfunction

    function automatic logic [ACC_W-1:0] model_sum(input int n, input bit want_q);
        longint acc = 0;
        for (int b = 0; b < n; b++)
            if (st_v[b])
                for (int l = 0; l < NL; l++) acc += rot(st_i[b][l], st_q[b][l], st_p[b][l], want_q);
        return ACC_W'(acc);
    endfunction

    task automatic fill_const(input int n, input int iv, input int qv, input int pidx);
        for (int b = 0; b < n; b++) begin
            st_v[b] = 1'b1;
            for (int l = 0; l < NL; l++) begin
                st_i[b][l] = iv;
                st_q[b][l] = qv;
                st_p[b][l] = int'($urandom_range(0, 4095)) * 64 + pidx;
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int b = 0; b < n; b++) begin
            st_v[b] = ($urandom_range(0, 4) != 0);
            for (int l = 0; l < NL; l++) begin
                st_i[b][l] = rand16();
                st_q[b][l] = rand16();
                st_p[b][l] = int'($urandom_range(0, 262143));
            end
        end
        st_v[n-1] = 1'b1;
    endtask

    task automatic junk_lanes();
        for (int l = 0; l < NL; l++) begin
            data_i_shift[l] = 16'($urandom);
            data_q_shift[l] = 16'($urandom);
            phase_vals[l]   = 18'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    // Drives one window from the st_* tables and records what the DUT produced
    task automatic drive_window(input int n, input int restart_at, input bit idle_junk, output obs_t o);
        if (idle_junk) begin
            in_valid = 1'b1; in_last = 1'b1; junk_lanes();
            tick();
        end
        start = 1'b1; in_valid = idle_junk; junk_lanes();
        tick();
        start = 1'b0;
        o.busy_run = busy;
        o.prev_i   = i_sum;
        for (int b = 0; b < n; b++) begin
            in_valid = st_v[b];
            in_last  = (b == n - 1) || (!st_v[b] && $urandom_range(0, 1) == 1);
            start    = (b == restart_at);
            for (int l = 0; l < NL; l++) begin
                data_i_shift[l] = 16'(st_i[b][l]);
                data_q_shift[l] = 16'(st_q[b][l]);
                phase_vals[l]   = 18'(st_p[b][l]);
            end
            tick();
        end
        start = 1'b0;
        o.lat = 0;
        while (result_valid !== 1'b1 && o.lat < 12) begin
            in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1)); junk_lanes();
            tick();
            o.lat++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        o.i = i_sum;
        o.q = q_sum;
        o.busy_rv = busy;
`ifdef DEMOD_THRESHOLD_EN
        o.qs = qubit_state;
`else
        o.qs = 1'b0;
`endif
        tick();
        o.rv_next = result_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk100);
        #1;
        n_checks += 4;
        if (i_sum !== '0) begin n_fail++; $display("FAIL reset_i_sum: got %0h expected 0", i_sum); end
        if (q_sum !== '0) begin n_fail++; $display("FAIL reset_q_sum: got %0h expected 0", q_sum); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_phase0();
        obs_t o;
        fill_const(10, 1000, 0, 0);
`ifdef DEMOD_THRESHOLD_EN
        threshold = '0;
`endif
        drive_window(10, -1, 1'b1, o);
        n_checks += 6;
        if (o.i !== ACC_W'(49950)) begin n_fail++; $display("FAIL phase0_i: got %0d expected 49950", $signed(o.i)); end
        if (o.q !== '0) begin n_fail++; $display("FAIL phase0_q: got %0d expected 0", $signed(o.q)); end
        if (o.lat !== 5) begin n_fail++; $display("FAIL phase0_latency: got %0d expected 5", o.lat); end
        if (o.rv_next !== 1'b0) begin n_fail++; $display("FAIL phase0_pulse_width: got %b expected 0", o.rv_next); end
        if (o.busy_run !== 1'b1) begin n_fail++; $display("FAIL phase0_busy_run: got %b expected 1", o.busy_run); end
        if (o.busy_rv !== 1'b0) begin n_fail++; $display("FAIL phase0_busy_at_result: got %b expected 0", o.busy_rv); end
`ifdef DEMOD_THRESHOLD_EN
        n_checks++;
        if (o.qs !== 1'b1) begin n_fail++; $display("FAIL phase0_qubit_state: got %b expected 1", o.qs); end
`endif
    endtask

    task automatic test_phase25();
        obs_t o;
        fill_const(10, 1000, 0, 25);
        drive_window(10, -1, 1'b0, o);
        n_checks += 3;
        if (o.i !== ACC_W'(-50000)) begin n_fail++; $display("FAIL phase25_i: got %0d expected -50000", $signed(o.i)); end
        if (o.q !== '0) begin n_fail++; $display("FAIL phase25_q: got %0d expected 0", $signed(o.q)); end
        if (o.lat !== 5) begin n_fail++; $display("FAIL phase25_latency: got %0d expected 5", o.lat); end
`ifdef DEMOD_THRESHOLD_EN
        n_checks++;
        if (o.qs !== 1'b0) begin n_fail++; $display("FAIL phase25_qubit_state: got %b expected 0", o.qs); end
`endif
    endtask

    task automatic test_q_only();
        obs_t o;
        fill_const(10, 0, 1000, 0);
        drive_window(10, -1, 1'b1, o);
        n_checks += 2;
        if (o.i !== '0) begin n_fail++; $display("FAIL qonly_i: got %0d expected 0", $signed(o.i)); end
        if (o.q !== ACC_W'(49950)) begin n_fail++; $display("FAIL qonly_q: got %0d expected 49950", $signed(o.q)); end
    endtask

    task automatic test_gaps();
        obs_t o;
        fill_const(12, 1000, 0, 0);
        foreach (st_i[2][l]) begin
            st_i[2][l] = rand16(); st_i[6][l] = rand16();
            st_q[2][l] = rand16(); st_q[6][l] = rand16();
        end
        st_v[2] = 1'b0;
        st_v[6] = 1'b0;
        drive_window(12, -1, 1'b0, o);
        n_checks += 2;
        if (o.i !== ACC_W'(49950)) begin n_fail++; $display("FAIL gaps_i: got %0d expected 49950", $signed(o.i)); end
        if (o.lat !== 5) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 5", o.lat); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_last = 1'b0;
            for (int l = 0; l < NL; l++) begin
                data_i_shift[l] = 16'(30000); data_q_shift[l] = 16'(-20000); phase_vals[l] = '0;
            end
            tick();
        end
        reset = 1'b1;
        #2;
        n_checks += 4;
        if (i_sum !== '0) begin n_fail++; $display("FAIL midreset_i_sum: got %0d expected 0", $signed(i_sum)); end
        if (q_sum !== '0) begin n_fail++; $display("FAIL midreset_q_sum: got %0d expected 0", $signed(q_sum)); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_result_valid: got %b expected 0", result_valid); end
        tick();
        reset = 1'b0; in_valid = 1'b0;
        tick();
        fill_const(2, 1000, 0, 0);
        drive_window(2, 1, 1'b0, o);
        n_checks += 3;
        if (o.i !== ACC_W'(9990)) begin n_fail++; $display("FAIL midreset_fresh_i: got %0d expected 9990", $signed(o.i)); end
        if (o.q !== '0) begin n_fail++; $display("FAIL midreset_fresh_q: got %0d expected 0", $signed(o.q)); end
        if (o.lat !== 5) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 5", o.lat); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [ACC_W-1:0] ei, eq;
        int n;
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(1, 20));
            fill_random(n);
            ei = model_sum(n, 1'b0);
            eq = model_sum(n, 1'b1);
`ifdef DEMOD_THRESHOLD_EN
            threshold = ACC_W'(int'($urandom_range(0, 2000000)) - 1000000);
`endif
            drive_window(n, (k % 2 == 1) ? int'($urandom_range(0, n - 1)) : -1, (k % 3 == 0), o);
            n_checks += 3;
            if (o.i !== ei) begin n_fail++; $display("FAIL random%0d_i: got %0d expected %0d", k, $signed(o.i), $signed(ei)); end
            if (o.q !== eq) begin n_fail++; $display("FAIL random%0d_q: got %0d expected %0d", k, $signed(o.q), $signed(eq)); end
            if (o.lat !== 5) begin n_fail++; $display("FAIL random%0d_latency: got %0d expected 5", k, o.lat); end
`ifdef DEMOD_THRESHOLD_EN
            n_checks++;
            if (o.qs !== ($signed(ei) > $signed(threshold))) begin
                n_fail++; $display("FAIL random%0d_qubit_state: got %b expected %b", k, o.qs, $signed(ei) > $signed(threshold));
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        logic [ACC_W-1:0] e1i, e2i, e2q;
        fill_random(7);
        e1i = model_sum(7, 1'b0);
        drive_window(7, -1, 1'b0, o1);
        fill_random(4);
        e2i = model_sum(4, 1'b0);
        e2q = model_sum(4, 1'b1);
        drive_window(4, -1, 1'b0, o2);
        n_checks += 5;
        if (o1.i !== e1i) begin n_fail++; $display("FAIL b2b_first_i: got %0d expected %0d", $signed(o1.i), $signed(e1i)); end
        if (o2.busy_run !== 1'b1) begin n_fail++; $display("FAIL b2b_start_accepted: got %b expected 1", o2.busy_run); end
        if (o2.prev_i !== e1i) begin n_fail++; $display("FAIL b2b_hold_i: got %0d expected %0d", $signed(o2.prev_i), $signed(e1i)); end
        if (o2.i !== e2i) begin n_fail++; $display("FAIL b2b_second_i: got %0d expected %0d", $signed(o2.i), $signed(e2i)); end
        if (o2.q !== e2q) begin n_fail++; $display("FAIL b2b_second_q: got %0d expected %0d", $signed(o2.q), $signed(e2q)); end
    endtask

    initial begin
        test_reset();
        test_phase0();
        test_phase25();
        test_q_only();
        test_gaps();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demod_integrator.md
# demod_integrator

Downstream stage of `sampler` in the readout chain. Takes the five-lane-per-clock phase-aligned I/Q stream (`data_i_shift`, `data_q_shift`, `phase_vals`) and digitally rotates each sample by the negative of its demodulation phase using a 50-entry cos/sin table. It integrates the rotated samples over one collection window and emits a single integrated I/Q pair per readout, which feeds qubit-state discrimination.

## Interface
- `LANES`, 5: samples per clock.
- `ACC_W`, 40: accumulator and result width.
- `clk100` input 1: 100 MHz system clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that arms a new integration; the same pulse that starts `sampler`.
- `in_valid` input 1: lane data valid this cycle.
- `in_last` input 1: final beat of the window; qualified by `in_valid`.
- `data_i_shift` input [4:0][15:0]: signed I samples, one per lane.
- `data_q_shift` input [4:0][15:0]: signed Q samples, one per lane.
- `phase_vals` input [4:0][17:0]: per-lane phase; bits [5:0] are the phase index 0..49; bits [17:6] are ignored.
- `i_sum` output [ACC_W-1:0]: signed integrated I; reset 0.
- `q_sum` output [ACC_W-1:0]: signed integrated Q; reset 0.
- `result_valid` output 1: one-cycle pulse when `i_sum`/`q_sum` update; reset 0.
- `busy` output 1: high outside IDLE; reset 0.

## Operation
- Table: cos[p] = round(32767·cos(2πp/50)) and sin[p] = round(32767·sin(2πp/50)), signed 16-bit. Phase indices 50..63 read as index 0.
- Per lane: I' = (I·cos + Q·sin) >>> 15 and Q' = (Q·cos − I·sin) >>> 15.
  - Products are 32-bit. Sums are 33-bit. The arithmetic shift floors the result to 18-bit signed.
- Beat sum: sign-extended sum of the 5 lane values, 21-bit. It is added into the 40-bit accumulators.
- FSM:
  - IDLE: `start` clears the pipeline and accumulators and moves to ACCUM.
  - ACCUM: each `in_valid` beat enters the pipeline. A beat with `in_valid & in_last` moves to DRAIN.
  - DRAIN: waits 4 cycles for the pipeline to flush, then moves to DONE.
  - DONE: registers `i_sum`/`q_sum`, pulses `result_valid`, returns to IDLE.
- Boundary rules:
  - `start` outside IDLE is ignored.
  - `in_valid` in IDLE, DRAIN or DONE is ignored.
  - `in_last` without `in_valid` is ignored.
  - Beats with `in_valid` low contribute nothing; the pipeline carries a valid bit.
  - Accumulator overflow wraps (two's complement); 40 bits cover more than 2^19 beats at full scale.
  - `i_sum`/`q_sum` hold their last result until the next DONE.
  - `reset` in any state returns to IDLE immediately and zeros all outputs and accumulators. Partial data is discarded.

## Timing
- Pipeline, with a beat sampled at edge T:
  - edge T+1: LUT lookup registered.
  - edge T+2: products registered.
  - edge T+3: lane sums and shift registered.
  - edge T+4: accumulate.
- Last beat sampled at edge T (`in_last`) → `result_valid` high during the cycle after edge T+5, for exactly one cycle.
- `busy` rises on the edge that samples `start` and falls on the edge that leaves DONE.
- The earliest accepted `start` is the cycle after `result_valid`, giving back-to-back windows.
- Throughput: one beat (5 samples) per clock, with no backpressure.

## Configuration
- Macro: `DEMOD_THRESHOLD_EN`.
- Defined:
  - Adds input `threshold` [ACC_W-1:0] (signed) and output `qubit_state` 1 (reset 0).
  - In DONE, `qubit_state` registers (final i_sum > `threshold`), updating in the same cycle as `result_valid`.
- Undefined: neither port exists and no comparator logic is built.

## Structure
- Package `demod_pkg`:
  - constants `DEMOD_LUT_SIZE`=50, `SAMPLE_W`=16, `LUT_W`=16, `LANE_OUT_W`=18, `ACC_W`=40;
  - FSM enum `demod_state_t` {IDLE, ACCUM, DRAIN, DONE};
  - constant cos/sin table arrays shared with the testbench reference model.
- Sub-module `demod_lane`: the LUT, multiply and shift stages for one lane, instantiated LANES times.
- Top level: lane summation, accumulators, FSM and the optional comparator.

## Test plan
- All lanes I=1000, Q=0, phase 0, 10 beats with `in_last` on beat 10 → i_sum=49950, q_sum=0; `result_valid` 5 cycles after the last beat.
- I=1000, Q=0, phase 25, 10 beats → i_sum=−50000, q_sum=0 (floor of −999.97 is −1000 per lane).
- I=0, Q=1000, phase 0, 10 beats → i_sum=0, q_sum=49950.
- `in_valid` low on beats 3 and 7 of a 12-cycle window, I=1000, phase 0 → 10 beats counted, i_sum=49950.
- `reset` pulsed mid-ACCUM, then a fresh `start` with 2 beats of I=1000, phase 0 → i_sum=9990; no stale data. A second `start` pulsed during ACCUM is ignored.
- With `DEMOD_THRESHOLD_EN` and threshold=0: the phase-0 run gives `qubit_state`=1 and the phase-25 run gives `qubit_state`=0, each coincident with `result_valid`.
